// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter for the shared SRAM slave port; optional timeout/abort under SRAM_ARB_TIMEOUT_EN
module sram_arbiter #(
  parameter int NREQ    = 2,
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               abus_clk,
  input  logic               abus_rstb,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ-1:0]    req_read,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    req_err,
  output logic [DW-1:0]      req_rdata,
  output logic               abus_swrite,
  output logic               abus_sread,
  output logic               abus_sabort,
  output logic [AW-1:0]      abus_saddr,
  output logic [DW-1:0]      abus_swdata,
  input  logic [DW-1:0]      abus_srdata,
  input  logic               abus_sready
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW1 = IW + 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("sram_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
`ifdef SRAM_ARB_TIMEOUT_EN
    ABORT,
`endif
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IW-1:0]     grant_q;
  logic [IW-1:0]     rr_ptr;
  logic              dir_q;
  logic [NREQ-1:0]   pending;
  logic [NREQ-1:0]   grant_oh;
  logic [AW-1:0]     addr_arr  [NREQ];
  logic [DW-1:0]     wdata_arr [NREQ];
  logic              win_any;
  logic [IW-1:0]     win_idx;
  logic              win_dir;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;
  logic [IW:0]       sum;
  logic [IW-1:0]     sel;
`ifdef SRAM_ARB_TIMEOUT_EN
  logic [7:0]        cnt_q;
  logic              err_q;
`endif

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*AW +: AW];
    assign wdata_arr[g] = req_wdata[g*DW +: DW];
  end

  assign pending  = req_write | req_read;
  assign grant_oh = NREQ'(1) << grant_q;

  // Round-robin pick: first pending requester at or after rr_ptr, wrapping; write wins over read
  always_comb begin
    win_any   = 1'b0;
    win_idx   = '0;
    win_dir   = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    sum       = '0;
    sel       = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + IW1'(i);
      if (sum >= IW1'(NREQ)) begin
        sum = sum - IW1'(NREQ);
      end
      sel = sum[IW-1:0];
      if (!win_any && pending[sel]) begin
        win_any   = 1'b1;
        win_idx   = sel;
        win_dir   = req_write[sel];
        win_addr  = addr_arr[sel];
        win_wdata = wdata_arr[sel];
      end
    end
  end

  // State register
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state strobes toward the SRAM controller and requesters
  always_comb begin
    state_d     = state_q;
    abus_swrite = 1'b0;
    abus_sread  = 1'b0;
    abus_sabort = 1'b0;
    req_ack     = '0;
    req_err     = '0;
    case (state_q)
      IDLE: begin
        if (win_any) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        abus_swrite = dir_q;
        abus_sread  = !dir_q;
        state_d     = WAIT;
      end
      WAIT: begin
        if (abus_sready) begin
          state_d = DONE;
        end
`ifdef SRAM_ARB_TIMEOUT_EN
        else if (cnt_q == 8'd0) begin
          state_d = ABORT;
        end
        // sready in the same cycle the count expires completes normally
`endif
      end
`ifdef SRAM_ARB_TIMEOUT_EN
      ABORT: begin
        abus_sabort = 1'b1;
        state_d     = DONE;
      end
`endif
      DONE: begin
        req_ack = grant_oh;
`ifdef SRAM_ARB_TIMEOUT_EN
        if (err_q) begin
          req_err = grant_oh;
        end
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction latches, read-data capture, timeout counter and round-robin pointer
  always_ff @(posedge abus_clk or negedge abus_rstb) begin
    if (!abus_rstb) begin
      grant_q     <= '0;
      rr_ptr      <= '0;
      dir_q       <= 1'b0;
      abus_saddr  <= '0;
      abus_swdata <= '0;
      req_rdata   <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_any) begin
            grant_q     <= win_idx;
            dir_q       <= win_dir;
            abus_saddr  <= win_addr;
            abus_swdata <= win_wdata;
`ifdef SRAM_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
          end
        end
        ISSUE: begin
`ifdef SRAM_ARB_TIMEOUT_EN
          cnt_q <= 8'(TIMEOUT);
`endif
        end
        WAIT: begin
          if (abus_sready) begin
            req_rdata <= dir_q ? '0 : abus_srdata;
          end
`ifdef SRAM_ARB_TIMEOUT_EN
          else if (cnt_q != 8'd0) begin
            cnt_q <= cnt_q - 8'd1;
          end
`endif
        end
`ifdef SRAM_ARB_TIMEOUT_EN
        ABORT: begin
          err_q     <= 1'b1;
          req_rdata <= '0;
        end
`endif
        DONE: begin
          rr_ptr <= (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 10;
  localparam int DW      = 32;
  localparam int TIMEOUT = 3;

  logic                abus_clk = 1'b0;
  logic                abus_rstb;
  logic [NREQ-1:0]     req_write;
  logic [NREQ-1:0]     req_read;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     req_err;
  logic [DW-1:0]       req_rdata;
  logic                abus_swrite;
  logic                abus_sread;
  logic                abus_sabort;
  logic [AW-1:0]       abus_saddr;
  logic [DW-1:0]       abus_swdata;
  logic [DW-1:0]       abus_srdata;
  logic                abus_sready;

  sram_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .abus_clk    (abus_clk),
    .abus_rstb   (abus_rstb),
    .req_write   (req_write),
    .req_read    (req_read),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ack     (req_ack),
    .req_err     (req_err),
    .req_rdata   (req_rdata),
    .abus_swrite (abus_swrite),
    .abus_sread  (abus_sread),
    .abus_sabort (abus_sabort),
    .abus_saddr  (abus_saddr),
    .abus_swdata (abus_swdata),
    .abus_srdata (abus_srdata),
    .abus_sready (abus_sready)
  );

  always #5 abus_clk = ~abus_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cd = 0;
  int slave_delay = 0;
  bit slave_en = 1'b1;
  int sread_cnt, swrite_cnt, sabort_cnt;
  int sabort_total = 0;
  int err_total = 0;
  int err_stray = 0;
  int addr_bad = 0;
  bit busy = 1'b0;
  logic [AW-1:0] busy_addr;
  int c0;

  int          ack_g  [$];
  logic [31:0] ack_rd [$];
  bit          ack_e  [$];
  int          ack_c  [$];
  bit          ev_dir [$];
  logic [9:0]  ev_addr[$];
  logic [31:0] ev_wd  [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [1:0] v);
    case (v)
      2'b01:   return 0;
      2'b10:   return 1;
      default: return 9;
    endcase
  endfunction

  task automatic clear_log();
    ack_g.delete(); ack_rd.delete(); ack_e.delete(); ack_c.delete();
    ev_dir.delete(); ev_addr.delete(); ev_wd.delete();
    sread_cnt = 0; swrite_cnt = 0; sabort_cnt = 0;
  endtask

  // One clock: sample outputs 1 unit after the edge, run the slave model, log events
  task automatic tick();
    @(posedge abus_clk);
    #1;
    cyc++;
    if (cd > 0) begin
      cd--;
      abus_sready = (cd == 0);
    end else begin
      abus_sready = 1'b0;
    end
    if (busy && abus_saddr !== busy_addr) addr_bad++;
    if (abus_sread || abus_swrite) begin
      sread_cnt  += int'(abus_sread);
      swrite_cnt += int'(abus_swrite);
      ev_dir.push_back(abus_swrite);
      ev_addr.push_back(abus_saddr);
      ev_wd.push_back(abus_swdata);
      busy      = 1'b1;
      busy_addr = abus_saddr;
      if (slave_en) cd = slave_delay + 1;
    end
    if (abus_sabort) begin
      sabort_cnt++;
      sabort_total++;
    end
    if ((req_err & ~req_ack) != '0) err_stray++;
    if (req_ack != '0) begin
      ack_g.push_back(oh2idx(req_ack));
      ack_rd.push_back(req_rdata);
      ack_e.push_back(req_err == req_ack);
      ack_c.push_back(cyc);
      if (req_err != '0) err_total++;
      busy = 1'b0;
    end
  endtask

  task automatic wait_ack(input int max, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      if (req_ack != '0) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  task automatic wait_strobe(input int max, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      if (abus_sread || abus_swrite) got = 1'b1;
    end
    chk(tag, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    abus_rstb   = 1'b0;
    req_write   = '0;
    req_read    = '0;
    req_addr    = '0;
    req_wdata   = '0;
    abus_srdata = '0;
    abus_sready = 1'b0;
    clear_log();
    repeat (2) tick();

    // reset state
    chk("rst_strobes", {abus_swrite, abus_sread, abus_sabort}, 0);
    chk("rst_ack_err", {req_ack, req_err}, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_saddr", abus_saddr, 0);
    chk("rst_swdata", abus_swdata, 0);
    abus_rstb = 1'b1;
    repeat (2) tick();
    chk("idle_no_strobe", sread_cnt + swrite_cnt, 0);

    // single read, sready in the third WAIT cycle
    clear_log();
    slave_delay = 2;
    abus_srdata = 32'hDEADBEEF;
    req_addr[9:0] = 10'h012;
    req_read[0] = 1'b1;
    c0 = cyc;
    wait_ack(20, "t1_ack_seen");
    req_read[0] = 1'b0;
    chk("t1_rdata", req_rdata, 32'hDEADBEEF);
    chk("t1_ack_grant", ack_g[0], 0);
    chk("t1_latency", ack_c[0] - c0, 5);
    repeat (4) tick();
    chk("t1_sread_cnt", sread_cnt, 1);
    chk("t1_swrite_cnt", swrite_cnt, 0);
    chk("t1_saddr", ev_addr[0], 10'h012);
    chk("t1_ack_cnt", ack_g.size(), 1);
    chk("t1_rdata_hold", req_rdata, 32'hDEADBEEF);

    // both requesters hold writes; last grant was 0 so 1 goes first
    clear_log();
    slave_delay = 0;
    req_addr  = {10'h201, 10'h100};
    req_wdata = {32'h22220001, 32'h11110000};
    req_write = 2'b11;
    c0 = cyc;
    for (int k = 0; k < 4; k++) wait_ack(20, "t2_ack_seen");
    req_write = '0;
    repeat (3) tick();
    chk("t2_grant0", ack_g[0], 1);
    chk("t2_grant1", ack_g[1], 0);
    chk("t2_grant2", ack_g[2], 1);
    chk("t2_grant3", ack_g[3], 0);
    chk("t2_wdata0", ev_wd[0], 32'h22220001);
    chk("t2_wdata1", ev_wd[1], 32'h11110000);
    chk("t2_addr2", ev_addr[2], 10'h201);
    chk("t2_addr3", ev_addr[3], 10'h100);
    chk("t2_swrite_cnt", swrite_cnt, 4);
    chk("t2_first_latency", ack_c[0] - c0, 3);
    chk("t2_back_to_back", ack_c[3] - ack_c[0], 12);
    chk("t2_rdata_write_zero", ack_rd[3], 0);

    // read and write together on requester 1: write first, then read
    clear_log();
    abus_srdata = 32'h5A5A1234;
    req_addr[19:10]  = 10'h0AB;
    req_wdata[63:32] = 32'hCAFEF00D;
    req_write[1] = 1'b1;
    req_read[1]  = 1'b1;
    wait_ack(20, "t3_ack_w");
    req_write[1] = 1'b0;
    wait_ack(20, "t3_ack_r");
    req_read[1] = 1'b0;
    repeat (3) tick();
    chk("t3_first_dir", ev_dir[0], 1);
    chk("t3_second_dir", ev_dir[1], 0);
    chk("t3_grants", {ack_g[0][3:0], ack_g[1][3:0]}, 8'h11);
    chk("t3_wdata", ev_wd[0], 32'hCAFEF00D);
    chk("t3_rdata_w", ack_rd[0], 0);
    chk("t3_rdata_r", ack_rd[1], 32'h5A5A1234);
    chk("t3_ack_cnt", ack_g.size(), 2);

    // request dropped and address changed during WAIT
    clear_log();
    slave_delay = 3;
    abus_srdata = 32'h0BADF00D;
    req_addr[9:0] = 10'h3C5;
    req_read[0] = 1'b1;
    wait_strobe(20, "t4_strobe_seen");
    tick();
    req_read[0] = 1'b0;
    req_addr[9:0] = 10'h000;
    wait_ack(20, "t4_ack_seen");
    chk("t4_saddr_done", abus_saddr, 10'h3C5);
    repeat (6) tick();
    chk("t4_grant", ack_g[0], 0);
    chk("t4_rdata", ack_rd[0], 32'h0BADF00D);
    chk("t4_ack_cnt", ack_g.size(), 1);
    chk("t4_sread_cnt", sread_cnt, 1);
    chk("t4_addr_stable", addr_bad, 0);

    // reset while in WAIT; afterwards requester 0 wins again
    slave_en = 1'b0;
    req_addr[9:0] = 10'h055;
    req_read[0] = 1'b1;
    wait_strobe(20, "t5_strobe_seen");
    tick();
    clear_log();
    abus_rstb = 1'b0;
    #1;
    chk("t5_rst_strobes", {abus_swrite, abus_sread, abus_sabort}, 0);
    chk("t5_rst_ack", {req_ack, req_err}, 0);
    chk("t5_rst_saddr", abus_saddr, 0);
    chk("t5_rst_rdata", req_rdata, 0);
    busy = 1'b0;
    cd = 0;
    abus_sready = 1'b0;
    req_addr[19:10] = 10'h066;
    req_read = 2'b11;
    slave_en = 1'b1;
    slave_delay = 0;
    tick();
    chk("t5_no_ack_in_rst", ack_g.size(), 0);
    abus_rstb = 1'b1;
    wait_ack(20, "t5_ack0");
    req_read[0] = 1'b0;
    wait_ack(20, "t5_ack1");
    req_read[1] = 1'b0;
    repeat (3) tick();
    chk("t5_grant0", ack_g[0], 0);
    chk("t5_addr0", ev_addr[0], 10'h055);
    chk("t5_grant1", ack_g[1], 1);
    chk("t5_addr1", ev_addr[1], 10'h066);
    chk("t5_no_abort", sabort_cnt, 0);

`ifdef SRAM_ARB_TIMEOUT_EN
    // sready never comes: abort, then ack with error
    clear_log();
    slave_en = 1'b0;
    abus_srdata = 32'hFFFFFFFF;
    req_addr[9:0] = 10'h077;
    req_read[0] = 1'b1;
    c0 = cyc;
    wait_ack(30, "t6_ack_seen");
    req_read[0] = 1'b0;
    chk("t6_rdata_zero", req_rdata, 0);
    repeat (3) tick();
    chk("t6_grant", ack_g[0], 0);
    chk("t6_err_with_ack", ack_e[0], 1);
    chk("t6_abort_cnt", sabort_cnt, 1);
    chk("t6_latency", ack_c[0] - c0, 7);

    // sready arrives in the cycle the count expires: normal completion
    clear_log();
    slave_en = 1'b1;
    slave_delay = 3;
    abus_srdata = 32'h13572468;
    req_addr[19:10] = 10'h088;
    req_read[1] = 1'b1;
    c0 = cyc;
    wait_ack(30, "t7_ack_seen");
    req_read[1] = 1'b0;
    repeat (3) tick();
    chk("t7_grant", ack_g[0], 1);
    chk("t7_no_err", req_err == '0 && ack_e[0] == 1'b0, 1);
    chk("t7_rdata", ack_rd[0], 32'h13572468);
    chk("t7_no_abort", sabort_cnt, 0);
    chk("t7_latency", ack_c[0] - c0, 6);
`else
    // without the timeout feature a slow slave is simply waited for
    clear_log();
    slave_en = 1'b1;
    slave_delay = 20;
    abus_srdata = 32'h2468ACE0;
    req_addr[19:10] = 10'h0CC;
    req_read[1] = 1'b1;
    c0 = cyc;
    wait_ack(40, "t6_ack_seen");
    req_read[1] = 1'b0;
    repeat (3) tick();
    chk("t6_grant", ack_g[0], 1);
    chk("t6_rdata", ack_rd[0], 32'h2468ACE0);
    chk("t6_latency", ack_c[0] - c0, 23);
    chk("t6_no_abort_total", sabort_total, 0);
    chk("t6_no_err_total", err_total, 0);
`endif

    chk("err_stray", err_stray, 0);
    chk("addr_stable_all", addr_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
